// File: rtl/cache_pkg.sv
// cache_pkg: shared definitions for the set-associative cache slice.
//   - default widths shared with the existing cache line
//   - controller state encoding
//   - age / statistics counter width helpers
package cache_pkg;

    localparam int unsigned DEF_ADDRESS_WORD_SIZE = 32;
    localparam int unsigned DEF_TAG_SIZE          = 19;
    localparam int unsigned DEF_WORD_SIZE         = 8;
    localparam int unsigned DEF_WAYS              = 4;
    localparam int unsigned DEF_OFFSET_BITS       = 2;

    // Width of the optional hit/miss statistics counters.
    localparam int unsigned STAT_W = 32;

    // Bits needed to hold an LRU age (0 .. ways-1); never narrower than 1.
    function automatic int unsigned age_width(input int unsigned ways);
        return (ways < 2) ? 1 : $clog2(ways);
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COMPARE,
        ST_EVICT,
        ST_FILL,
        ST_RESP
    } cache_state_e;

endpackage

// File: rtl/cache_lru.sv
// cache_lru: true-LRU age tracking for one cache set.
//   clk, rst_b  : clock, asynchronous active-low reset (age[i] = i)
//   access_en   : update ages for an access to access_way this cycle
//   access_way  : way being accessed
//   valid       : per-way valid bits, used for victim selection
//   victim      : lowest-index invalid way, else the way with the oldest age
module cache_lru
    import cache_pkg::*;
#(
    parameter int unsigned WAYS  = DEF_WAYS,
    parameter int unsigned AGE_W = age_width(WAYS)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             access_en,
    input  logic [AGE_W-1:0] access_way,
    input  logic [WAYS-1:0]  valid,
    output logic [AGE_W-1:0] victim
);

    logic [AGE_W-1:0] age [WAYS];
    logic             found_invalid;

    // Ages stay a permutation of 0..WAYS-1: the accessed way becomes 0 and
    // only the ways younger than it shift up by one.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int unsigned i = 0; i < WAYS; i++) begin
                age[i] <= AGE_W'(i);
            end
        end else if (access_en) begin
            for (int unsigned i = 0; i < WAYS; i++) begin
                if (AGE_W'(i) == access_way) begin
                    age[i] <= '0;
                end else if (age[i] < age[access_way]) begin
                    age[i] <= age[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        victim        = '0;
        found_invalid = 1'b0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (!found_invalid && !valid[i]) begin
                victim        = AGE_W'(i);
                found_invalid = 1'b1;
            end
        end
        if (!found_invalid) begin
            for (int unsigned i = 0; i < WAYS; i++) begin
                if (age[i] == AGE_W'(WAYS - 1)) begin
                    victim = AGE_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/cache_set_assoc.sv
// cache_set_assoc: one set of an N-way set-associative write-back cache.
//   Core side   : req_valid/req_ready/req_write/req_addr/req_wdata,
//                 rsp_valid/rsp_hit/rsp_rdata (one-cycle pulse, no backpressure)
//   Eviction    : evict_valid/evict_ready with evict_tag/offset/data,
//                 word-serial write-back of a dirty victim line
//   Refill      : fill_ready/fill_valid with fill_tag/offset/data,
//                 word-serial line refill
//   Optional    : define CACHE_SET_STATS_EN to add saturating 32-bit
//                 hit_count / miss_count outputs.
module cache_set_assoc
    import cache_pkg::*;
#(
    parameter int unsigned ADDRESS_WORD_SIZE = DEF_ADDRESS_WORD_SIZE,
    parameter int unsigned TAG_SIZE          = DEF_TAG_SIZE,
    parameter int unsigned WORD_SIZE         = DEF_WORD_SIZE,
    parameter int unsigned WAYS              = DEF_WAYS,
    parameter int unsigned OFFSET_BITS       = DEF_OFFSET_BITS
) (
    input  logic                         clk,
    input  logic                         rst_b,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [ADDRESS_WORD_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0]         req_wdata,
    output logic                         rsp_valid,
    output logic                         rsp_hit,
    output logic [WORD_SIZE-1:0]         rsp_rdata,
    output logic                         evict_valid,
    input  logic                         evict_ready,
    output logic [TAG_SIZE-1:0]          evict_tag,
    output logic [OFFSET_BITS-1:0]       evict_offset,
    output logic [WORD_SIZE-1:0]         evict_data,
    output logic                         fill_ready,
    input  logic                         fill_valid,
    output logic [TAG_SIZE-1:0]          fill_tag,
    output logic [OFFSET_BITS-1:0]       fill_offset,
    input  logic [WORD_SIZE-1:0]         fill_data
`ifdef CACHE_SET_STATS_EN
    ,
    output logic [STAT_W-1:0]            hit_count,
    output logic [STAT_W-1:0]            miss_count
`endif
);

    localparam int unsigned LINE  = 2 ** OFFSET_BITS;
    localparam int unsigned AGE_W = age_width(WAYS);

    cache_state_e state, state_next;

    logic                   r_write;
    logic [TAG_SIZE-1:0]    r_tag;
    logic [OFFSET_BITS-1:0] r_off;
    logic [WORD_SIZE-1:0]   r_wdata;

    logic [WAYS-1:0]        valid;
    logic [WAYS-1:0]        dirty;
    logic [TAG_SIZE-1:0]    tags [WAYS];
    logic [WORD_SIZE-1:0]   data [WAYS][LINE];

    logic                   hit;
    logic [AGE_W-1:0]       hit_way;
    logic [AGE_W-1:0]       lru_victim;
    logic [AGE_W-1:0]       vic_q;
    logic                   lru_en;
    logic [AGE_W-1:0]       lru_way;
    logic [OFFSET_BITS-1:0] beat;
    logic                   beat_last;
    logic                   ev_fire;
    logic                   fill_fire;
    logic                   hit_q;
    logic [WORD_SIZE-1:0]   rdata_q;

    // Set-index bits of the address are decoded upstream and not needed here.
    logic                   unused_addr;
    assign unused_addr = ^req_addr;

    assign beat_last = (beat == '1);
    assign ev_fire   = (state == ST_EVICT) && evict_ready;
    assign fill_fire = (state == ST_FILL) && fill_valid;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (!hit && valid[i] && (tags[i] == r_tag)) begin
                hit     = 1'b1;
                hit_way = AGE_W'(i);
            end
        end
    end

    // LRU is touched on a hit in COMPARE or when the refill completes.
    assign lru_en  = ((state == ST_COMPARE) && hit) || (fill_fire && beat_last);
    assign lru_way = (state == ST_COMPARE) ? hit_way : vic_q;

    cache_lru #(
        .WAYS  (WAYS),
        .AGE_W (AGE_W)
    ) u_lru (
        .clk        (clk),
        .rst_b      (rst_b),
        .access_en  (lru_en),
        .access_way (lru_way),
        .valid      (valid),
        .victim     (lru_victim)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:    if (req_valid) state_next = ST_COMPARE;
            ST_COMPARE: begin
                if (hit)                                         state_next = ST_RESP;
                else if (valid[lru_victim] && dirty[lru_victim]) state_next = ST_EVICT;
                else                                             state_next = ST_FILL;
            end
            ST_EVICT:   if (ev_fire && beat_last)   state_next = ST_FILL;
            ST_FILL:    if (fill_fire && beat_last) state_next = ST_RESP;
            ST_RESP:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    assign req_ready    = (state == ST_IDLE);
    assign rsp_valid    = (state == ST_RESP);
    assign rsp_hit      = rsp_valid && hit_q;
    assign rsp_rdata    = rsp_valid ? rdata_q : '0;
    assign evict_valid  = (state == ST_EVICT);
    assign evict_tag    = evict_valid ? tags[vic_q] : '0;
    assign evict_offset = evict_valid ? beat : '0;
    assign evict_data   = evict_valid ? data[vic_q][beat] : '0;
    assign fill_ready   = (state == ST_FILL);
    assign fill_tag     = fill_ready ? r_tag : '0;
    assign fill_offset  = fill_ready ? beat : '0;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state   <= ST_IDLE;
            r_write <= 1'b0;
            r_tag   <= '0;
            r_off   <= '0;
            r_wdata <= '0;
            valid   <= '0;
            dirty   <= '0;
            vic_q   <= '0;
            beat    <= '0;
            hit_q   <= 1'b0;
            rdata_q <= '0;
            for (int unsigned i = 0; i < WAYS; i++) begin
                tags[i] <= '0;
                for (int unsigned j = 0; j < LINE; j++) begin
                    data[i][j] <= '0;
                end
            end
        end else begin
            state <= state_next;
            unique case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_write <= req_write;
                        r_tag   <= req_addr[ADDRESS_WORD_SIZE-1 -: TAG_SIZE];
                        r_off   <= req_addr[OFFSET_BITS-1:0];
                        r_wdata <= req_wdata;
                    end
                end
                ST_COMPARE: begin
                    beat <= '0;
                    if (hit) begin
                        hit_q <= 1'b1;
                        if (r_write) begin
                            data[hit_way][r_off] <= r_wdata;
                            dirty[hit_way]       <= 1'b1;
                            rdata_q              <= r_wdata;
                        end else begin
                            rdata_q <= data[hit_way][r_off];
                        end
                    end else begin
                        hit_q <= 1'b0;
                        vic_q <= lru_victim;
                    end
                end
                // beat wraps back to 0 after the last word, ready for FILL.
                ST_EVICT: begin
                    if (evict_ready) beat <= beat + 1'b1;
                end
                ST_FILL: begin
                    if (fill_valid) begin
                        data[vic_q][beat] <= fill_data;
                        beat              <= beat + 1'b1;
                        if (beat_last) begin
                            tags[vic_q]  <= r_tag;
                            valid[vic_q] <= 1'b1;
                            dirty[vic_q] <= r_write;
                            // Written word overrides the refill word at its offset
                            // (later assignment wins when it is also the last beat).
                            if (r_write) begin
                                data[vic_q][r_off] <= r_wdata;
                                rdata_q            <= r_wdata;
                            end else if (r_off == beat) begin
                                rdata_q <= fill_data;
                            end else begin
                                rdata_q <= data[vic_q][r_off];
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CACHE_SET_STATS_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == ST_COMPARE) begin
            if (hit) begin
                if (hit_count != '1) hit_count <= hit_count + 1'b1;
            end else begin
                if (miss_count != '1) miss_count <= miss_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_set_assoc.sv
// tb_cache_set_assoc: self-checking bench for cache_set_assoc.
// A recency-list model predicts hits, victims, eviction lines and read data;
// one compare process checks handshake outputs every cycle, and each directed
// request is also checked against hand-computed literals.
module tb_cache_set_assoc;

    localparam int AW = 32, TW = 19, WW = 8, NW = 4, OB = 2, LINE = 4;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          req_valid = 1'b0, req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [WW-1:0] req_wdata = '0;
    logic          req_ready, rsp_valid, rsp_hit;
    logic [WW-1:0] rsp_rdata;
    logic          evict_valid, evict_ready = 1'b0;
    logic [TW-1:0] evict_tag, fill_tag;
    logic [OB-1:0] evict_offset, fill_offset;
    logic [WW-1:0] evict_data, fill_data = '0;
    logic          fill_ready, fill_valid = 1'b0;
`ifdef CACHE_SET_STATS_EN
    logic [31:0]   hit_count, miss_count;
`endif

    always #5 clk = ~clk;

    cache_set_assoc #(
        .ADDRESS_WORD_SIZE (AW), .TAG_SIZE (TW), .WORD_SIZE (WW),
        .WAYS (NW), .OFFSET_BITS (OB)
    ) dut (
        .clk (clk), .rst_b (rst_b),
        .req_valid (req_valid), .req_ready (req_ready), .req_write (req_write),
        .req_addr (req_addr), .req_wdata (req_wdata),
        .rsp_valid (rsp_valid), .rsp_hit (rsp_hit), .rsp_rdata (rsp_rdata),
        .evict_valid (evict_valid), .evict_ready (evict_ready), .evict_tag (evict_tag),
        .evict_offset (evict_offset), .evict_data (evict_data),
        .fill_ready (fill_ready), .fill_valid (fill_valid), .fill_tag (fill_tag),
        .fill_offset (fill_offset), .fill_data (fill_data)
`ifdef CACHE_SET_STATS_EN
        , .hit_count (hit_count), .miss_count (miss_count)
`endif
    );

    int n_checks = 0, n_pass = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // ---------------- model ----------------
    logic          m_valid [NW];
    logic          m_dirty [NW];
    logic [TW-1:0] m_tag   [NW];
    logic [WW-1:0] m_data  [NW][LINE];
    int            lru_q[$];          // front = most recently used
    int            m_hits, m_misses;

    logic          exp_hit, exp_evict;
    logic [TW-1:0] exp_ev_tag, exp_fill_tag;
    logic [WW-1:0] exp_ev_line [LINE];
    logic [WW-1:0] exp_rdata;
    int            exp_lat;

    logic          got_hit;
    logic [WW-1:0] got_rdata;
    int            got_lat;
    logic [WW-1:0] got_ev [LINE];
    int            ev_beat = 0, fl_beat = 0;

    function automatic void model_reset();
        for (int i = 0; i < NW; i++) begin
            m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0;
            for (int j = 0; j < LINE; j++) m_data[i][j] = '0;
        end
        lru_q = {};
        for (int i = 0; i < NW; i++) lru_q.push_back(i);
        m_hits = 0; m_misses = 0;
    endfunction

    function automatic void touch(input int w);
        int idx;
        idx = 0;
        foreach (lru_q[i]) if (lru_q[i] == w) idx = i;
        lru_q.delete(idx);
        lru_q.push_front(w);
    endfunction

    function automatic void model_txn(input logic wr, input logic [AW-1:0] addr,
                                      input logic [WW-1:0] wd, input logic [WW-1:0] base,
                                      input int stall);
        logic [TW-1:0] tag;
        int off, way;
        tag = addr[AW-1 -: TW];
        off = int'(addr[OB-1:0]);
        way = -1;
        for (int i = 0; i < NW; i++) if (way < 0 && m_valid[i] && m_tag[i] == tag) way = i;
        exp_fill_tag = tag;
        exp_evict    = 1'b0;
        if (way >= 0) begin
            exp_hit = 1'b1; m_hits++;
            if (wr) begin m_data[way][off] = wd; m_dirty[way] = 1'b1; end
            exp_rdata = m_data[way][off];
            exp_lat   = 2;
        end else begin
            exp_hit = 1'b0; m_misses++;
            for (int i = 0; i < NW; i++) if (way < 0 && !m_valid[i]) way = i;
            if (way < 0) way = lru_q[$];
            exp_evict  = m_valid[way] && m_dirty[way];
            exp_ev_tag = m_tag[way];
            for (int j = 0; j < LINE; j++) begin
                exp_ev_line[j] = m_data[way][j];
                m_data[way][j] = WW'(int'(base) + j);
            end
            if (wr) m_data[way][off] = wd;
            m_tag[way] = tag; m_valid[way] = 1'b1; m_dirty[way] = wr;
            exp_rdata = m_data[way][off];
            exp_lat   = 2 + LINE + (exp_evict ? LINE + stall : 0);
        end
        touch(way);
    endfunction

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk); #3;
            if (!rst_b) begin
                ev_beat = 0; fl_beat = 0;
            end else begin
                if (evict_valid) begin
                    check("evict_valid", 32'(evict_valid), 32'(exp_evict));
                    check("evict_tag", 32'(evict_tag), 32'(exp_ev_tag));
                    check("evict_offset", 32'(evict_offset), ev_beat);
                    check("evict_data", 32'(evict_data), 32'(exp_ev_line[ev_beat % LINE]));
                    if (evict_ready) begin
                        got_ev[ev_beat % LINE] = evict_data;
                        ev_beat++;
                    end
                end
                if (fill_ready) begin
                    check("fill_tag", 32'(fill_tag), 32'(exp_fill_tag));
                    check("fill_offset", 32'(fill_offset), fl_beat);
                    check("evict_before_fill", ev_beat, exp_evict ? LINE : 0);
                    if (fill_valid) fl_beat++;
                end
                if (rsp_valid) begin
                    check("rsp_hit", 32'(rsp_hit), 32'(exp_hit));
                    check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
                    check("fill_beats", fl_beat, exp_hit ? 0 : LINE);
                    ev_beat = 0; fl_beat = 0;
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic access(input logic wr, input logic [AW-1:0] addr, input logic [WW-1:0] wd,
                          input logic [WW-1:0] base, input int stall);
        int c, stall_left, fbeat;
        model_txn(wr, addr, wd, base, stall);
        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 1);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        fill_valid = 1'b1; fill_data = 8'hEE; evict_ready = 1'b1;
        stall_left = stall; fbeat = 0; c = 0;
        do begin
            @(negedge clk); c++;
            // Scramble request inputs: the DUT must use the latched copy.
            req_valid = 1'b0; req_write = ~wr; req_addr = ~addr; req_wdata = ~wd;
            if (evict_valid && stall_left > 0) begin
                evict_ready = 1'b0; stall_left--;
            end else begin
                evict_ready = 1'b1;
            end
            if (fill_ready) begin
                fill_data = WW'(int'(base) + fbeat); fbeat++;
            end else begin
                fill_data = 8'hEE;
            end
        end while (!rsp_valid && c < 64);
        got_lat = c; got_hit = rsp_hit; got_rdata = rsp_rdata;
        check("latency", c, exp_lat);
        fill_valid = 1'b0; evict_ready = 1'b0;
        @(negedge clk);
        check("req_ready_after_rsp", 32'(req_ready), 1);
        check("rsp_single_pulse", 32'(rsp_valid), 0);
    endtask

    task automatic lit(input string name, input logic hit, input logic [WW-1:0] rdata, input int lat);
        check({name, "_hit"}, 32'(got_hit), 32'(hit));
        check({name, "_rdata"}, 32'(got_rdata), 32'(rdata));
        check({name, "_lat"}, got_lat, lat);
    endtask

    // Start a read miss, then pull reset while the FILL expects beat 2.
    task automatic abort_in_fill(input logic [AW-1:0] addr);
        int c, fbeat;
        model_txn(1'b0, addr, '0, 8'hC0, 0);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = addr; fill_valid = 1'b1;
        c = 0; fbeat = 0;
        do begin
            @(negedge clk); c++;
            req_valid = 1'b0;
            if (fill_ready) begin
                if (fbeat == 2) break;
                fill_data = WW'(8'hC0 + fbeat); fbeat++;
            end
        end while (c < 32);
        check("abort_fill_beats", fbeat, 2);
        rst_b = 1'b0;
        #1;
        check("abort_req_ready", 32'(req_ready), 1);
        check("abort_fill_ready", 32'(fill_ready), 0);
        check("abort_rsp_valid", 32'(rsp_valid), 0);
        fill_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_hit", 32'(rsp_hit), 0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 0);
        check("rst_evict_valid", 32'(evict_valid), 0);
        check("rst_fill_ready", 32'(fill_ready), 0);
        check("rst_evict_tag", 32'(evict_tag), 0);
        check("rst_fill_tag", 32'(fill_tag), 0);
        rst_b = 1'b1;

        access(1'b0, 32'h0000_1002, 8'h00, 8'hA0, 0); lit("cold_read", 1'b0, 8'hA2, 6);
        access(1'b0, 32'h0000_1002, 8'h00, 8'h00, 0); lit("hit_read", 1'b1, 8'hA2, 2);
        access(1'b1, 32'h0000_1002, 8'h5C, 8'h00, 0); lit("hit_write", 1'b1, 8'h5C, 2);
        access(1'b0, 32'h0000_1002, 8'h00, 8'h00, 0); lit("read_back", 1'b1, 8'h5C, 2);

        access(1'b0, 32'h0000_2000, 8'h00, 8'h10, 0); lit("fill_t1", 1'b0, 8'h10, 6);
        access(1'b0, 32'h0000_4000, 8'h00, 8'h20, 0); lit("fill_t2", 1'b0, 8'h20, 6);
        access(1'b0, 32'h0000_6000, 8'h00, 8'h30, 0); lit("fill_t3", 1'b0, 8'h30, 6);
        access(1'b0, 32'h0000_1003, 8'h00, 8'h00, 0); lit("touch_t0", 1'b1, 8'hA3, 2);
        access(1'b0, 32'h0000_8000, 8'h00, 8'h40, 0); lit("miss_t4", 1'b0, 8'h40, 6);
        access(1'b0, 32'h0000_1000, 8'h00, 8'h00, 0); lit("t0_kept", 1'b1, 8'hA0, 2);
        access(1'b0, 32'h0000_4001, 8'h00, 8'h00, 0); lit("t2_kept", 1'b1, 8'h21, 2);
        access(1'b0, 32'h0000_6002, 8'h00, 8'h00, 0); lit("t3_kept", 1'b1, 8'h32, 2);
        access(1'b0, 32'h0000_2003, 8'h00, 8'h50, 0); lit("t1_evicted", 1'b0, 8'h53, 6);

        access(1'b1, 32'h0000_A001, 8'h77, 8'h60, 3); lit("dirty_miss", 1'b0, 8'h77, 13);
        check("evicted_w0", 32'(got_ev[0]), 32'h0000_00A0);
        check("evicted_w2", 32'(got_ev[2]), 32'h0000_005C);
        access(1'b0, 32'h0000_A001, 8'h00, 8'h00, 0); lit("merged_word", 1'b1, 8'h77, 2);
        access(1'b0, 32'h0000_A000, 8'h00, 8'h00, 0); lit("merged_fill", 1'b1, 8'h60, 2);

        abort_in_fill(32'h0000_C000);
        access(1'b0, 32'h0000_2003, 8'h00, 8'h80, 0); lit("after_abort", 1'b0, 8'h83, 6);
`ifdef CACHE_SET_STATS_EN
        check("hit_count", hit_count, 32'(m_hits));
        check("miss_count", miss_count, 32'(m_misses));
`endif
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
